ucsbece154b_dmem_dual: RTL
==========================

Name: ucsbece154b_dmem_dual

Overview:
- Data-memory responder for the dual-issue pipeline. It answers both M-stage data ports (slot 1 is older, slot 2 is younger) on the memory side of the core's MemWriteM/ALUResultM/WriteDataM/ReadDataM interface.
- Stores are accepted into a small in-order store buffer, which drains one word per cycle into a single-write-port RAM.
- Loads read combinationally, with store-to-load forwarding from the buffer and from a same-cycle older slot.
- StallM_o back-pressures the hazard unit when the buffer cannot take two more stores.

Parameters:
- ADDR_W, 10, word-address width; RAM holds 2^ADDR_W 32-bit words.
- SB_DEPTH, 4, store-buffer entries; power of 2, minimum 4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- MemWriteM_i1  in  1  slot-1 store valid
- ALUResultM_i1  in  32  slot-1 byte address
- WriteDataM_i1  in  32  slot-1 store data
- ReadDataM_o1  out  32  slot-1 load data, combinational
- MemWriteM_i2  in  1  slot-2 store valid
- ALUResultM_i2  in  32  slot-2 byte address
- WriteDataM_i2  in  32  slot-2 store data
- ReadDataM_o2  out  32  slot-2 load data, combinational
- StallM_o  out  1  buffer near full; core must hold M stage
- SbEmpty_o  out  1  store buffer empty, for fence and test use

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values:
  - head, tail and count = 0; all entry valid bits = 0.
  - StallM_o = 0, SbEmpty_o = 1.
  - RAM contents are not reset.
  - Asserting reset mid-operation discards pending stores. No partial RAM write occurs on that edge.
- Addressing:
  - Word-only accesses. Word index = addr[ADDR_W+1:2]; addr[1:0] are ignored.
  - If addr[31:ADDR_W+2] != 0 the address is out of range: reads return 32'h0 and stores are dropped (not enqueued).
- Store buffer: circular FIFO. Each entry holds {valid, word index, data}.
  - count width is clog2(SB_DEPTH)+1. Pointers wrap modulo SB_DEPTH.
  - StallM_o = (count_q >= SB_DEPTH-1). It depends on registered state only, with no combinational path from the inputs.
- Enqueue (posedge, only when StallM_o = 0):
  - The slot-1 store takes entry tail.
  - The slot-2 store takes the next free entry after any slot-1 store.
  - Enqueue count is 0, 1 or 2.
  - When StallM_o = 1, inputs are ignored. The core holds its M stage and re-presents the stores.
- Drain (posedge): if count_q > 0, the head entry is written to the RAM and head advances.
- Simultaneous enqueue and drain:
  - next count = count_q + enq - drain.
  - The StallM_o threshold guarantees no overflow: the worst case is count SB_DEPTH-2 with 2 enqueued and 1 drained, giving SB_DEPTH-1.
- Same-word stores in one cycle: both are enqueued in age order, so the slot-2 value is the final RAM value.
- Load priority for port 2:
  - 1st: a same-cycle slot-1 store (MemWriteM_i1, in range) to the same word forwards WriteDataM_i1.
  - 2nd: the youngest valid buffer entry matching the word.
  - 3rd: RAM.
- Load priority for port 1: youngest matching buffer entry, then RAM. Port 1 never sees a same-cycle slot-2 store.
- Both ports read RAM at the same time; the RAM has two combinational read ports and one write port.
- Loads and stores have zero latency from the core's view; visibility through forwarding is immediate.
- SbEmpty_o = (count_q == 0).

Decomposition:
- Shared header holds:
  - UCSBECE154B_WORD_W = 32
  - default ADDR_W and SB_DEPTH
  - entry field offsets (valid, index, data)
- Sub-module ucsbece154b_store_buffer: FIFO storage, pointers and count, the two-entry enqueue, one drain port, and a youngest-match CAM lookup for two read ports.
- The top-level ucsbece154b_dmem_dual contains:
  - the RAM array
  - range checks
  - the same-cycle slot-1 to slot-2 bypass
  - the read muxes

Test Plan:
- Reset behaviour: drive reset=0 mid-run with 3 entries pending, release it → StallM_o=0 and SbEmpty_o=1 immediately (asynchronously). Pending words never reach the RAM; a RAM readback returns the old values.
- Intra-cycle bypass: slot 1 stores 0xDEADBEEF to 0x100 while slot 2 loads 0x100 in the same cycle → ReadDataM_o2=0xDEADBEEF in that cycle, and ReadDataM_o1 on a load of 0x100 returns the old RAM value.
- Same-word dual store: both slots store to 0x40, slot 1=0x11 and slot 2=0x22 → the next-cycle load returns 0x22. After SbEmpty_o=1 the RAM word is 0x22.
- Fill and stall: dual stores to 8 distinct words back-to-back, SB_DEPTH=4 → StallM_o=1 once count reaches 3. No entry is lost or overwritten; after the core stops storing, the buffer drains one word per cycle and all 8 words read back correctly.
- Forward priority: store 0x1 then 0x2 to 0x80 in consecutive cycles and load 0x80 before the drain completes → the load returns 0x2, the youngest matching entry.
- Range and alignment: store 0x55 to 0x0000_1003 with ADDR_W=10 → dropped, and the load returns 0. Store to 0x3FF and read back at 0x3FC → 0x55.

Source files
------------

// File: rtl/ucsbece154b_dmem_dual_pkg.sv
// Shared constants for the dual-port data memory and its store buffer.
// Store-buffer entries are packed as {valid, word index, data}, data at the LSBs.
package ucsbece154b_dmem_dual_pkg;

   localparam int UCSBECE154B_WORD_W   = 32;
   localparam int UCSBECE154B_ADDR_W   = 10;
   localparam int UCSBECE154B_SB_DEPTH = 4;

   localparam int UCSBECE154B_ENT_DATA_LSB = 0;
   localparam int UCSBECE154B_ENT_IDX_LSB  = UCSBECE154B_ENT_DATA_LSB + UCSBECE154B_WORD_W;

   function automatic int ent_vld_bit(input int addr_w);
      return UCSBECE154B_ENT_IDX_LSB + addr_w;
   endfunction

   function automatic int ent_w(input int addr_w);
      return ent_vld_bit(addr_w) + 1;
   endfunction

endpackage

// File: rtl/ucsbece154b_store_buffer.sv
// In-order store buffer: two-store enqueue, one-word drain per cycle,
// and a youngest-match lookup for two read ports.
module ucsbece154b_store_buffer
   import ucsbece154b_dmem_dual_pkg::*;
#(
   parameter int ADDR_W   = UCSBECE154B_ADDR_W,
   parameter int SB_DEPTH = UCSBECE154B_SB_DEPTH
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enq1_i,
   input  logic [ADDR_W-1:0]                   idx1_i,
   input  logic [UCSBECE154B_WORD_W-1:0]       data1_i,
   input  logic                                enq2_i,
   input  logic [ADDR_W-1:0]                   idx2_i,
   input  logic [UCSBECE154B_WORD_W-1:0]       data2_i,
   input  logic [1:0][ADDR_W-1:0]              rd_idx_i,
   output logic [1:0]                          rd_hit_o,
   output logic [1:0][UCSBECE154B_WORD_W-1:0]  rd_data_o,
   output logic                                drain_o,
   output logic [ADDR_W-1:0]                   drain_idx_o,
   output logic [UCSBECE154B_WORD_W-1:0]       drain_data_o,
   output logic                                stall_o,
   output logic                                empty_o
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ent_w(ADDR_W);
   localparam int VLD_B = ent_vld_bit(ADDR_W);
   localparam int IDX_L = UCSBECE154B_ENT_IDX_LSB;
   localparam int DAT_L = UCSBECE154B_ENT_DATA_LSB;

   logic [ENT_W-1:0] ent_q [SB_DEPTH];
   logic [ENT_W-1:0] ent_d [SB_DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, tail2;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             e1, e2, drain;

   // Threshold leaves room for a worst-case dual enqueue, so no overflow check is needed
   assign stall_o = (cnt_q >= CNT_W'(SB_DEPTH - 1));
   assign empty_o = (cnt_q == '0);
   assign drain   = ~empty_o;
   assign e1      = enq1_i & ~stall_o;
   assign e2      = enq2_i & ~stall_o;
   assign tail2   = tail_q + PTR_W'(e1);

   assign drain_o      = drain;
   assign drain_idx_o  = ent_q[head_q][VLD_B-1:IDX_L];
   assign drain_data_o = ent_q[head_q][DAT_L +: UCSBECE154B_WORD_W];

   always_comb begin
      ent_d = ent_q;
      if (drain) ent_d[head_q][VLD_B] = 1'b0;
      if (e1)    ent_d[tail_q] = {1'b1, idx1_i, data1_i};
      if (e2)    ent_d[tail2]  = {1'b1, idx2_i, data2_i};
      head_d = head_q + PTR_W'(drain);
      tail_d = tail2 + PTR_W'(e2);
      cnt_d  = cnt_q + CNT_W'(e1) + CNT_W'(e2) - CNT_W'(drain);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < SB_DEPTH; i++) ent_q[i] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         for (int i = 0; i < SB_DEPTH; i++) ent_q[i] <= ent_d[i];
      end
   end

   // Walk oldest to youngest from head; the last match wins
   always_comb begin
      rd_hit_o  = '0;
      rd_data_o = '0;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < SB_DEPTH; k++) begin
            if (ent_q[head_q + PTR_W'(k)][VLD_B] &&
                ent_q[head_q + PTR_W'(k)][VLD_B-1:IDX_L] == rd_idx_i[r]) begin
               rd_hit_o[r]  = 1'b1;
               rd_data_o[r] = ent_q[head_q + PTR_W'(k)][DAT_L +: UCSBECE154B_WORD_W];
            end
         end
      end
   end

endmodule

// File: rtl/ucsbece154b_dmem_dual.sv
// Dual-slot data memory: RAM with two read ports, store buffer in front of the
// single write port, and slot-1 to slot-2 same-cycle store forwarding.
module ucsbece154b_dmem_dual
   import ucsbece154b_dmem_dual_pkg::*;
#(
   parameter int ADDR_W   = UCSBECE154B_ADDR_W,
   parameter int SB_DEPTH = UCSBECE154B_SB_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          MemWriteM_i1,
   input  logic [UCSBECE154B_WORD_W-1:0] ALUResultM_i1,
   input  logic [UCSBECE154B_WORD_W-1:0] WriteDataM_i1,
   output logic [UCSBECE154B_WORD_W-1:0] ReadDataM_o1,
   input  logic                          MemWriteM_i2,
   input  logic [UCSBECE154B_WORD_W-1:0] ALUResultM_i2,
   input  logic [UCSBECE154B_WORD_W-1:0] WriteDataM_i2,
   output logic [UCSBECE154B_WORD_W-1:0] ReadDataM_o2,
   output logic                          StallM_o,
   output logic                          SbEmpty_o
);

   logic [UCSBECE154B_WORD_W-1:0]       mem_q [2**ADDR_W];
   logic                                rng1, rng2;
   logic [ADDR_W-1:0]                   idx1, idx2;
   logic [1:0]                          sb_hit;
   logic [1:0][UCSBECE154B_WORD_W-1:0]  sb_data;
   logic                                drain;
   logic [ADDR_W-1:0]                   drain_idx;
   logic [UCSBECE154B_WORD_W-1:0]       drain_data;
   logic                                unused_lsbs;

   assign rng1 = (ALUResultM_i1[UCSBECE154B_WORD_W-1:ADDR_W+2] == '0);
   assign rng2 = (ALUResultM_i2[UCSBECE154B_WORD_W-1:ADDR_W+2] == '0);
   assign idx1 = ALUResultM_i1[ADDR_W+1:2];
   assign idx2 = ALUResultM_i2[ADDR_W+1:2];
   assign unused_lsbs = ^{ALUResultM_i1[1:0], ALUResultM_i2[1:0]};

   ucsbece154b_store_buffer #(
      .ADDR_W   (ADDR_W),
      .SB_DEPTH (SB_DEPTH)
   ) u_sb (
      .clk          (clk),
      .reset        (reset),
      .enq1_i       (MemWriteM_i1 & rng1),
      .idx1_i       (idx1),
      .data1_i      (WriteDataM_i1),
      .enq2_i       (MemWriteM_i2 & rng2),
      .idx2_i       (idx2),
      .data2_i      (WriteDataM_i2),
      .rd_idx_i     ({idx2, idx1}),
      .rd_hit_o     (sb_hit),
      .rd_data_o    (sb_data),
      .drain_o      (drain),
      .drain_idx_o  (drain_idx),
      .drain_data_o (drain_data),
      .stall_o      (StallM_o),
      .empty_o      (SbEmpty_o)
   );

   // Qualify with reset so an edge arriving during reset never commits a store
   always_ff @(posedge clk) begin
      if (reset && drain) mem_q[drain_idx] <= drain_data;
   end

   always_comb begin
      ReadDataM_o1 = '0;
      ReadDataM_o2 = '0;
      if (rng1) ReadDataM_o1 = sb_hit[0] ? sb_data[0] : mem_q[idx1];
      if (rng2) begin
         if (MemWriteM_i1 && rng1 && (idx1 == idx2)) ReadDataM_o2 = WriteDataM_i1;
         else if (sb_hit[1])                        ReadDataM_o2 = sb_data[1];
         else                                       ReadDataM_o2 = mem_q[idx2];
      end
   end

endmodule
